// File: rtl/vec_mul_pkg.sv
// Shared types and default constants for the vector-matrix multiply sequencer.
package vec_mul_pkg;

  localparam int ADDRESSSIZE  = 10;
  localparam int LEN_BW       = 11;
  localparam int WEIGHT_BANKS = 4;
  localparam int WBANK_BW     = 2;
  localparam int WLOAD_CYC    = 2;
  localparam int PIPE_LATENCY = 17;
  localparam int RD_LAT       = 1;
  localparam int TOTAL_LAT    = RD_LAT + PIPE_LATENCY;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } state_e;

endpackage

// File: rtl/vec_mul_seq_ctrl_valid_delay_line.sv
// valid_delay_line: 1-bit shift register that aligns UB read issues with result writes.
module valid_delay_line #(
  parameter int DEPTH = 18
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  input  logic din,
  output logic dout,
  output logic drained
);

  // Every stage except the output one; when these are clear the line is empty after this edge.
  localparam logic [DEPTH-1:0] BODY_MASK = ~(DEPTH'(1) << (DEPTH-1));

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = flush ? '0 : ((sr_q << 1) | DEPTH'(din));
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign dout    = sr_q[DEPTH-1];
  assign drained = ~|(sr_q & BODY_MASK);

endmodule

// File: rtl/vec_mul_seq_ctrl.sv
// vec_mul_seq_ctrl: programmable job sequencer (weight reload, UB streaming, aligned result writes).
// Define PERF_CNT_EN to add the 32-bit busy-cycle counter output cycle_cnt.
module vec_mul_seq_ctrl #(
  parameter int ADDRESSSIZE  = vec_mul_pkg::ADDRESSSIZE,
  parameter int LEN_BW       = vec_mul_pkg::LEN_BW,
  parameter int WEIGHT_BANKS = vec_mul_pkg::WEIGHT_BANKS,
  parameter int WBANK_BW     = vec_mul_pkg::WBANK_BW,
  parameter int WLOAD_CYC    = vec_mul_pkg::WLOAD_CYC,
  parameter int PIPE_LATENCY = vec_mul_pkg::PIPE_LATENCY,
  parameter int RD_LAT       = vec_mul_pkg::RD_LAT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] cfg_in_base,
  input  logic [ADDRESSSIZE-1:0] cfg_out_base,
  input  logic [LEN_BW-1:0]      cfg_len,
  input  logic [WBANK_BW-1:0]    cfg_wbank,
  output logic                   busy,
  output logic                   done,
  output logic [WBANK_BW-1:0]    wsram_addr,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   ub_rd_en,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   cfg_err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]            cycle_cnt
`endif
);

  import vec_mul_pkg::*;

  localparam int DEPTH = RD_LAT + PIPE_LATENCY;
  localparam int WL_BW = (WLOAD_CYC > 1) ? $clog2(WLOAD_CYC) : 1;

  state_e                 state_q, state_d;
  logic [LEN_BW-1:0]      rem_q, rem_d;
  logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
  logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
  logic [WBANK_BW-1:0]    wsram_q, wsram_d;
  logic [WL_BW-1:0]       wl_cnt_q, wl_cnt_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   flush;
  logic                   drained;
  logic                   bank_ok;
  logic                   job_accept;

  // One extra bit so WEIGHT_BANKS == 2**WBANK_BW is still representable.
  assign bank_ok    = {1'b0, cfg_wbank} < (WBANK_BW+1)'(WEIGHT_BANKS);
  assign job_accept = (state_q == ST_IDLE) && start && bank_ok;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    ub_addr_d     = ub_addr_q;
    res_addr_d    = res_addr_q;
    wsram_d       = wsram_q;
    wl_cnt_d      = wl_cnt_q;
    cfg_err_d     = cfg_err_q;
    flush         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    weight_reload = 1'b0;
    ub_rd_en      = 1'b0;

    if (res_we) res_addr_d = res_addr_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Abort is not considered here, so a simultaneous start always wins.
        if (start) begin
          wsram_d    = cfg_wbank;
          ub_addr_d  = cfg_in_base;
          res_addr_d = cfg_out_base;
          rem_d      = cfg_len;
          wl_cnt_d   = '0;
          if (!bank_ok)              cfg_err_d = 1'b1;
          else if (cfg_len == '0)    state_d   = ST_FIN;
          else                       state_d   = ST_WLOAD;
        end
      end
      ST_WLOAD: begin
        busy          = 1'b1;
        weight_reload = 1'b1;
        wl_cnt_d      = wl_cnt_q + 1'b1;
        if (wl_cnt_q == WL_BW'(WLOAD_CYC - 1)) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        busy      = 1'b1;
        ub_rd_en  = 1'b1;
        ub_addr_d = ub_addr_q + 1'b1;
        rem_d     = rem_q - 1'b1;
        if (rem_q == LEN_BW'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave on the edge that retires the last write, so done follows it directly.
        if (drained) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      ub_addr_q  <= '0;
      res_addr_q <= '0;
      wsram_q    <= '0;
      wl_cnt_q   <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      ub_addr_q  <= ub_addr_d;
      res_addr_q <= res_addr_d;
      wsram_q    <= wsram_d;
      wl_cnt_q   <= wl_cnt_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  valid_delay_line #(
    .DEPTH (DEPTH)
  ) u_valid_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .din     (ub_rd_en),
    .dout    (res_we),
    .drained (drained)
  );

  assign wsram_addr = wsram_q;
  assign ub_addr    = ub_addr_q;
  assign res_addr   = res_addr_q;
  assign cfg_err    = cfg_err_q;

`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (job_accept) cyc_cnt_d = '0;
    else if (busy)  cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cyc_cnt_q <= '0;
    else       cyc_cnt_q <= cyc_cnt_d;
  end

  assign cycle_cnt = cyc_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = job_accept;
`endif

endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
// Scoreboard bench for vec_mul_seq_ctrl: a job-level model schedules expected events by cycle,
// a negedge monitor matches them against what the DUT presents.
module tb_vec_mul_seq_ctrl;

  localparam int AW   = 10;
  localparam int LW   = 11;
  localparam int NB   = 4;
  localparam int BW   = 3;        // wide enough that bank 5 is encodable
  localparam int WL   = 2;
  localparam int LAT  = 1 + 17;   // UB read latency + array latency
  localparam int AMOD = 1 << AW;
  localparam int K_WL = 0, K_RD = 1, K_WR = 2, K_DONE = 3;
  localparam int NEVER = 32'h7fff_ffff;

  typedef struct { int cyc; int val; } ev_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] cfg_in_base = '0;
  logic [AW-1:0] cfg_out_base = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [BW-1:0] cfg_wbank = '0;
  logic          busy, done, weight_reload, ub_rd_en, res_we, cfg_err;
  logic [BW-1:0] wsram_addr;
  logic [AW-1:0] ub_addr, res_addr;
`ifdef PERF_CNT_EN
  logic [31:0]   cycle_cnt;
`endif

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  ev_t   evq[4][$];
  int    free_cyc = 0;
  int    busy_lo = 1;
  int    busy_hi = 0;
  int    err_from = NEVER;
  bit    mon_en = 1'b0;
  string names[4] = '{"weight_reload", "ub_read", "res_write", "done"};

  vec_mul_seq_ctrl #(
    .ADDRESSSIZE (AW), .LEN_BW (LW), .WEIGHT_BANKS (NB), .WBANK_BW (BW),
    .WLOAD_CYC (WL), .PIPE_LATENCY (17), .RD_LAT (1)
  ) dut (
    .clk (clk), .rstn (rstn), .start (start), .abort (abort),
    .cfg_in_base (cfg_in_base), .cfg_out_base (cfg_out_base),
    .cfg_len (cfg_len), .cfg_wbank (cfg_wbank),
    .busy (busy), .done (done), .wsram_addr (wsram_addr),
    .weight_reload (weight_reload), .ub_addr (ub_addr), .ub_rd_en (ub_rd_en),
    .res_we (res_we), .res_addr (res_addr), .cfg_err (cfg_err)
`ifdef PERF_CNT_EN
    , .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic present, input int val);
    ev_t e;
    if (present) begin
      if (evq[k].size() == 0) begin
        checks++; failures++;
        $display("FAIL %s unexpected at cycle %0d: got 0x%0h, expected none", names[k], cyc, val);
      end else begin
        e = evq[k].pop_front();
        check({names[k], "_cycle"}, cyc, e.cyc);
        if (k != K_DONE) check({names[k], "_value"}, val, e.val);
      end
    end else begin
      while (evq[k].size() > 0 && evq[k][0].cyc <= cyc) begin
        e = evq[k].pop_front();
        checks++; failures++;
        $display("FAIL %s missing at cycle %0d: got none, expected 0x%0h", names[k], e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rstn && mon_en) begin
      mon(K_WL, weight_reload, int'(wsram_addr));
      mon(K_RD, ub_rd_en, int'(ub_addr));
      mon(K_WR, res_we, int'(res_addr));
      mon(K_DONE, done, 0);
      check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      check("cfg_err", int'(cfg_err), int'(cyc >= err_from));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Job as seen from outside: WL reload cycles, len reads, each read echoed LAT cycles later.
  task automatic model_job(input int a, input int in_b, input int out_b, input int len, input int wb);
    if (wb >= NB) begin
      if (a < err_from) err_from = a;
      return;
    end
    if (len == 0) begin
      evq[K_DONE].push_back(ev_t'{a, 0});
      free_cyc = a + 1;
      return;
    end
    for (int i = 0; i < WL; i++) evq[K_WL].push_back(ev_t'{a + i, wb});
    for (int i = 0; i < len; i++) begin
      evq[K_RD].push_back(ev_t'{a + WL + i, (in_b + i) % AMOD});
      evq[K_WR].push_back(ev_t'{a + WL + i + LAT, (out_b + i) % AMOD});
    end
    evq[K_DONE].push_back(ev_t'{a + WL + len + LAT, 0});
    busy_lo  = a;
    busy_hi  = a + WL + len + LAT - 1;
    free_cyc = busy_hi + 2;
  endtask

  task automatic model_abort(input int k);
    ev_t keep[$];
    for (int q = 0; q < 4; q++) begin
      keep = {};
      for (int i = 0; i < evq[q].size(); i++)
        if (evq[q][i].cyc <= k) keep.push_back(evq[q][i]);
      evq[q] = keep;
    end
    if (k < busy_hi) busy_hi = k;
    free_cyc = k + 1;
  endtask

  task automatic run_job(input int in_b, input int out_b, input int len, input int wb, input int abort_off);
    int a;
    while (cyc < free_cyc) step();
    cfg_in_base  = AW'(in_b);
    cfg_out_base = AW'(out_b);
    cfg_len      = LW'(len);
    cfg_wbank    = BW'(wb);
    start        = 1'b1;
    a = cyc + 1;
    model_job(a, in_b, out_b, len, wb);
    step();
    start = 1'b0;
    if (abort_off >= 0 && wb < NB) begin
      while (cyc < a + abort_off) step();
      abort = 1'b1;
      model_abort(cyc);
      step();
      abort = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_wsram_addr"}, int'(wsram_addr), 0);
    check({tag, "_weight_reload"}, int'(weight_reload), 0);
    check({tag, "_ub_addr"}, int'(ub_addr), 0);
    check({tag, "_ub_rd_en"}, int'(ub_rd_en), 0);
    check({tag, "_res_we"}, int'(res_we), 0);
    check({tag, "_res_addr"}, int'(res_addr), 0);
    check({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  initial begin
    int ln, ab, a;
    #1 rstn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) step();
    rstn = 1'b1;
    free_cyc = cyc;
    mon_en = 1'b1;

    // Directed job, then start held with other config while it is busy.
    run_job(12'h010, 12'h100, 4, 2, -1);
    cfg_in_base = 10'h200; cfg_out_base = 10'h300; cfg_len = 11'd7; cfg_wbank = 3'd1;
    start = 1'b1;
    repeat (5) step();
    start = 1'b0;

    // Address wrap on both sides.
    run_job(12'h3FE, 12'h3FF, 3, 0, -1);
    // Zero-length job.
    run_job(12'h055, 12'h066, 0, 3, -1);
    // Abort after three reads, then a normal job.
    run_job(12'h120, 12'h220, 10, 1, WL + 2);
    run_job(12'h020, 12'h040, 5, 3, -1);
    // Abort coinciding with start in IDLE: start must win.
    while (cyc < free_cyc) step();
    abort = 1'b1;
    run_job(12'h0A0, 12'h0B0, 2, 0, -1);
    abort = 1'b0;
    // Out-of-range bank: flagged, no job runs.
    run_job(12'h000, 12'h000, 6, 5, -1);
    run_job(12'h030, 12'h031, 2, 1, -1);

    for (int j = 0; j < 12; j++) begin
      ln = $urandom_range(0, 40);
      ab = ($urandom_range(0, 3) == 0 && ln > 0) ? $urandom_range(0, ln + WL + LAT - 1) : -1;
      repeat ($urandom_range(0, 3)) step();
      run_job($urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1), ln,
              $urandom_range(0, NB - 1), ab);
    end

    // Reset in the middle of streaming.
    run_job(12'h005, 12'h007, 20, 1, -1);
    a = cyc;
    while (cyc < a + 4) step();
    rstn = 1'b0;
    for (int q = 0; q < 4; q++) evq[q] = {};
    busy_hi  = -1;
    err_from = NEVER;
    #1 check_reset_outputs("mid_reset");
    repeat (2) step();
    rstn = 1'b1;
    free_cyc = cyc;
    run_job(12'h3F0, 12'h010, 6, 2, -1);

    while (cyc < free_cyc + 5) step();
    for (int q = 0; q < 4; q++) check({"leftover_", names[q]}, evq[q].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
